// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard / forwarding controller.
// Forwarding select values drive the 4-input operand muxes in ID.
package pipe_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      FWD_RF     = 2'b00,
      FWD_EXALU  = 2'b01,
      FWD_MEMALU = 2'b10,
      FWD_MEMLD  = 2'b11
   } fwd_sel_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Control bus between the pipeline datapath and the hazard controller.
// Level-based, no handshake: every output is valid every cycle from current inputs and state.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 4);

   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_use_rs;
   logic             id_use_rt;
   logic             id_is_md;
   logic             id_is_mfhilo;
   logic [4:0]       ex_rn;
   logic             ex_wreg;
   logic             ex_m2reg;
   logic [4:0]       mem_rn;
   logic             mem_wreg;
   logic             mem_m2reg;

   logic [1:0]       fwda;
   logic [1:0]       fwdb;
   logic             wpcir;
   logic             bubble;
   logic             md_start;
   logic             md_busy;
   logic [31:0]      stall_cnt;
   logic [CNT_W-1:0] md_cnt;

   modport master (
      output id_rs, id_rt, id_use_rs, id_use_rt, id_is_md, id_is_mfhilo,
             ex_rn, ex_wreg, ex_m2reg, mem_rn, mem_wreg, mem_m2reg,
      input  fwda, fwdb, wpcir, bubble, md_start, md_busy, stall_cnt, md_cnt
   );

   modport slave (
      input  id_rs, id_rt, id_use_rs, id_use_rt, id_is_md, id_is_mfhilo,
             ex_rn, ex_wreg, ex_m2reg, mem_rn, mem_wreg, mem_m2reg,
      output fwda, fwdb, wpcir, bubble, md_start, md_busy, stall_cnt, md_cnt
   );

endinterface

// File: rtl/pipe_fwd_sel.sv
// Per-operand forwarding select generator; also flags a load-use match
// against the instruction currently in EX.
module pipe_fwd_sel
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic [4:0] id_rn,
   input  logic       id_use,
   input  logic [4:0] ex_rn,
   input  logic       ex_wreg,
   input  logic       ex_m2reg,
   input  logic [4:0] mem_rn,
   input  logic       mem_wreg,
   input  logic       mem_m2reg,
   output fwd_sel_t   fwd,
   output logic       lu_match
);

   logic ex_hit;
   logic mem_hit;

   assign ex_hit  = ex_wreg  & (ex_rn  == id_rn);
   assign mem_hit = mem_wreg & (mem_rn == id_rn);

   // EX is younger than MEM, so it wins when both write the same register.
   always_comb begin
      fwd = FWD_RF;
      if (id_rn == REG_ZERO || !id_use) begin
         fwd = FWD_RF;
      end else if (ex_hit && !ex_m2reg) begin
         fwd = FWD_EXALU;
      end else if (mem_hit && !mem_m2reg) begin
         fwd = FWD_MEMALU;
      end else if (mem_hit && mem_m2reg) begin
         fwd = FWD_MEMLD;
      end
   end

   assign lu_match = id_use & ex_wreg & ex_m2reg & (ex_rn != REG_ZERO) & (ex_rn == id_rn);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller: operand forwarding selects, load-use and
// MDU-busy stalls, MDU start sequencing and a stall-cycle counter.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MD_LAT = 4,
   parameter int CNT_W  = 4
)(
   input  logic clock,
   input  logic reset,
   pipe_hazard_ctrl_if.slave hz
);

   fwd_sel_t         fwd_a;
   fwd_sel_t         fwd_b;
   logic             lu_a;
   logic             lu_b;
   logic             lu;
   logic [CNT_W-1:0] md_cnt;
   logic [31:0]      stall_cnt;
   logic             md_busy_i;
   logic             md_stall;
   logic             stall;
   logic             md_start_i;

   pipe_fwd_sel u_fwd_rs (
      .id_rn     (hz.id_rs),
      .id_use    (hz.id_use_rs),
      .ex_rn     (hz.ex_rn),
      .ex_wreg   (hz.ex_wreg),
      .ex_m2reg  (hz.ex_m2reg),
      .mem_rn    (hz.mem_rn),
      .mem_wreg  (hz.mem_wreg),
      .mem_m2reg (hz.mem_m2reg),
      .fwd       (fwd_a),
      .lu_match  (lu_a)
   );

   pipe_fwd_sel u_fwd_rt (
      .id_rn     (hz.id_rt),
      .id_use    (hz.id_use_rt),
      .ex_rn     (hz.ex_rn),
      .ex_wreg   (hz.ex_wreg),
      .ex_m2reg  (hz.ex_m2reg),
      .mem_rn    (hz.mem_rn),
      .mem_wreg  (hz.mem_wreg),
      .mem_m2reg (hz.mem_m2reg),
      .fwd       (fwd_b),
      .lu_match  (lu_b)
   );

   assign lu         = lu_a | lu_b;
   assign md_busy_i  = (md_cnt != '0);
   assign md_stall   = md_busy_i & (hz.id_is_md | hz.id_is_mfhilo);
   assign stall      = lu | md_stall;
   // A start blocked by any stall simply retries when the instruction is re-presented.
   assign md_start_i = hz.id_is_md & ~stall;

   always_ff @(posedge clock) begin
      if (reset) begin
         md_cnt    <= '0;
         stall_cnt <= 32'd0;
      end else begin
         if (md_start_i) begin
            md_cnt <= CNT_W'(MD_LAT);
         end else if (md_busy_i) begin
            md_cnt <= md_cnt - CNT_W'(1);
         end
         if (stall) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
      end
   end

   // During reset the ID/EX register is flushed but fetch keeps running.
   assign hz.fwda      = reset ? FWD_RF : fwd_a;
   assign hz.fwdb      = reset ? FWD_RF : fwd_b;
   assign hz.wpcir     = reset ? 1'b1 : ~stall;
   assign hz.bubble    = reset ? 1'b1 : stall;
   assign hz.md_start  = md_start_i & ~reset;
   assign hz.md_busy   = md_busy_i & ~reset;
   assign hz.stall_cnt = stall_cnt;
   assign hz.md_cnt    = md_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with a queue-based scoreboard.
module tb_pipe_hazard_ctrl;

   localparam int EW = 44;

   logic clock;
   logic reset;
   logic [EW-1:0] exp_q[$];
   string         name_q[$];
   int            n_cmp;
   int            n_err;
   logic          drv_done;

   pipe_hazard_ctrl_if #(.CNT_W(4)) hz ();

   pipe_hazard_ctrl #(.MD_LAT(4), .CNT_W(4)) dut (
      .clock (clock),
      .reset (reset),
      .hz    (hz)
   );

   // clock / reset
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic logic [EW-1:0] pack_exp(
      input logic [1:0] fa, input logic [1:0] fb, input logic wp, input logic bub,
      input logic mst, input logic busy, input logic [3:0] cnt, input logic [31:0] sc);
      return {fa, fb, wp, bub, mst, busy, cnt, sc};
   endfunction

   // driver
   task automatic step(
      input string nm, input logic rst,
      input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
      input logic md, input logic mf,
      input logic [4:0] exrn, input logic exw, input logic exl,
      input logic [4:0] memrn, input logic memw, input logic meml,
      input logic [EW-1:0] e);
      @(posedge clock);
      #1;
      reset           = rst;
      hz.id_rs        = rs;
      hz.id_rt        = rt;
      hz.id_use_rs    = urs;
      hz.id_use_rt    = urt;
      hz.id_is_md     = md;
      hz.id_is_mfhilo = mf;
      hz.ex_rn        = exrn;
      hz.ex_wreg      = exw;
      hz.ex_m2reg     = exl;
      hz.mem_rn       = memrn;
      hz.mem_wreg     = memw;
      hz.mem_m2reg    = meml;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // scoreboard monitor
   always @(negedge clock) begin
      logic [EW-1:0] act;
      logic [EW-1:0] e;
      string         nm;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         nm  = name_q.pop_front();
         act = {hz.fwda, hz.fwdb, hz.wpcir, hz.bubble, hz.md_start, hz.md_busy,
                hz.md_cnt, hz.stall_cnt};
         n_cmp = n_cmp + 1;
         if (act !== e) begin
            n_err = n_err + 1;
            $display("FAIL %s: got fa=%b fb=%b wp=%b bub=%b st=%b busy=%b cnt=%0d sc=%0d, expected fa=%b fb=%b wp=%b bub=%b st=%b busy=%b cnt=%0d sc=%0d",
                     nm, act[43:42], act[41:40], act[39], act[38], act[37], act[36], act[35:32], act[31:0],
                     e[43:42], e[41:40], e[39], e[38], e[37], e[36], e[35:32], e[31:0]);
         end
      end
   end

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      drv_done = 1'b0;
      reset    = 1'b1;
      hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_use_rs = 1'b0; hz.id_use_rt = 1'b0;
      hz.id_is_md = 1'b0; hz.id_is_mfhilo = 1'b0;
      hz.ex_rn = 5'd0; hz.ex_wreg = 1'b0; hz.ex_m2reg = 1'b0;
      hz.mem_rn = 5'd0; hz.mem_wreg = 1'b0; hz.mem_m2reg = 1'b0;
      repeat (2) @(posedge clock);

      //   name          rst rs    rt    urs  urt  md   mf   exrn  exw  exl  memrn memw meml
      step("rst",        1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, pack_exp(2'b00, 2'b00, 1, 1, 0, 0, 4'd0, 32'd0));
      step("rst_md",     1, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, 5'd0, 0, 0, pack_exp(2'b00, 2'b00, 1, 1, 0, 0, 4'd0, 32'd0));
      step("fwd_ex",     0, 5'd5, 5'd0, 1, 0, 0, 0, 5'd5, 1, 0, 5'd0, 0, 0, pack_exp(2'b01, 2'b00, 1, 0, 0, 0, 4'd0, 32'd0));
      step("fwd_ex_pri", 0, 5'd5, 5'd0, 1, 0, 0, 0, 5'd5, 1, 0, 5'd5, 1, 0, pack_exp(2'b01, 2'b00, 1, 0, 0, 0, 4'd0, 32'd0));
      step("fwd_mem",    0, 5'd5, 5'd0, 1, 0, 0, 0, 5'd6, 1, 0, 5'd5, 1, 0, pack_exp(2'b10, 2'b00, 1, 0, 0, 0, 4'd0, 32'd0));
      step("lu_stall",   0, 5'd0, 5'd8, 0, 1, 0, 0, 5'd8, 1, 1, 5'd0, 0, 0, pack_exp(2'b00, 2'b00, 0, 1, 0, 0, 4'd0, 32'd0));
      step("lu_fwd",     0, 5'd0, 5'd8, 0, 1, 0, 0, 5'd0, 0, 0, 5'd8, 1, 1, pack_exp(2'b00, 2'b11, 1, 0, 0, 0, 4'd0, 32'd1));
      step("r0",         0, 5'd0, 5'd0, 1, 1, 0, 0, 5'd0, 1, 1, 5'd0, 1, 0, pack_exp(2'b00, 2'b00, 1, 0, 0, 0, 4'd0, 32'd1));
      step("use_off",    0, 5'd5, 5'd5, 0, 0, 0, 0, 5'd5, 1, 1, 5'd5, 1, 0, pack_exp(2'b00, 2'b00, 1, 0, 0, 0, 4'd0, 32'd1));
      step("fwd_both",   0, 5'd4, 5'd7, 1, 1, 0, 0, 5'd4, 1, 0, 5'd7, 1, 1, pack_exp(2'b01, 2'b11, 1, 0, 0, 0, 4'd0, 32'd1));
      step("mult",       0, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, 5'd0, 0, 0, pack_exp(2'b00, 2'b00, 1, 0, 1, 0, 4'd0, 32'd1));
      step("mfhi_1",     0, 5'd0, 5'd0, 0, 0, 0, 1, 5'd0, 0, 0, 5'd0, 0, 0, pack_exp(2'b00, 2'b00, 0, 1, 0, 1, 4'd4, 32'd1));
      step("mfhi_2",     0, 5'd0, 5'd0, 0, 0, 0, 1, 5'd0, 0, 0, 5'd0, 0, 0, pack_exp(2'b00, 2'b00, 0, 1, 0, 1, 4'd3, 32'd2));
      step("mfhi_3",     0, 5'd0, 5'd0, 0, 0, 0, 1, 5'd0, 0, 0, 5'd0, 0, 0, pack_exp(2'b00, 2'b00, 0, 1, 0, 1, 4'd2, 32'd3));
      step("mfhi_4",     0, 5'd0, 5'd0, 0, 0, 0, 1, 5'd0, 0, 0, 5'd0, 0, 0, pack_exp(2'b00, 2'b00, 0, 1, 0, 1, 4'd1, 32'd4));
      step("mfhi_go",    0, 5'd0, 5'd0, 0, 0, 0, 1, 5'd0, 0, 0, 5'd0, 0, 0, pack_exp(2'b00, 2'b00, 1, 0, 0, 0, 4'd0, 32'd5));
      step("mult_lu",    0, 5'd9, 5'd0, 1, 0, 1, 0, 5'd9, 1, 1, 5'd0, 0, 0, pack_exp(2'b00, 2'b00, 0, 1, 0, 0, 4'd0, 32'd5));
      step("mult_retry", 0, 5'd9, 5'd0, 1, 0, 1, 0, 5'd0, 0, 0, 5'd9, 1, 1, pack_exp(2'b11, 2'b00, 1, 0, 1, 0, 4'd0, 32'd6));
      step("busy_lu",    0, 5'd3, 5'd0, 1, 0, 0, 0, 5'd3, 1, 1, 5'd0, 0, 0, pack_exp(2'b00, 2'b00, 0, 1, 0, 1, 4'd4, 32'd6));
      step("busy_md",    0, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, 5'd0, 0, 0, pack_exp(2'b00, 2'b00, 0, 1, 0, 1, 4'd3, 32'd7));
      step("rst_mid",    1, 5'd5, 5'd0, 1, 0, 1, 1, 5'd5, 1, 0, 5'd0, 0, 0, pack_exp(2'b00, 2'b00, 1, 1, 0, 0, 4'd2, 32'd8));
      step("rst_hold",   1, 5'd0, 5'd0, 0, 0, 0, 1, 5'd0, 0, 0, 5'd0, 0, 0, pack_exp(2'b00, 2'b00, 1, 1, 0, 0, 4'd0, 32'd0));
      step("post_rst",   0, 5'd0, 5'd0, 0, 0, 0, 1, 5'd0, 0, 0, 5'd0, 0, 0, pack_exp(2'b00, 2'b00, 1, 0, 0, 0, 4'd0, 32'd0));
      drv_done = 1'b1;
   end

   // final report
   initial begin
      int budget;
      budget = 0;
      wait (drv_done === 1'b1);
      while (exp_q.size() > 0 && budget < 20) begin
         @(posedge clock);
         budget++;
      end
      if (exp_q.size() > 0) begin
         n_cmp = n_cmp + 1;
         n_err = n_err + 1;
         $display("FAIL drain_timeout: got %0d pending entries, expected 0", exp_q.size());
      end
      @(posedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
